// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter slice: FSM encoding and a
// width helper usable in parameter context.
package fpga_modules_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Smallest r with 2**r >= v; bounded so the shift never reaches the sign bit.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between the requesters, the consumer and the arbiter.
// The consumer's done pulse is release_pulse because "release" is a reserved word.
interface onehot_rr_arbiter_if
   import fpga_modules_pkg::*;
#(
   parameter int in_val = 4,
   parameter int idx_w  = clog2_f(in_val)
) ();
   logic [in_val-1:0] req;
   logic              release_pulse;
   logic [in_val-1:0] grant;
   logic              grant_valid;
   logic [idx_w-1:0]  grant_idx;

   modport master (
      output req, release_pulse,
      input  grant, grant_valid, grant_idx
   );

   modport slave (
      input  req, release_pulse,
      output grant, grant_valid, grant_idx
   );
endinterface

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational circular first-set search starting at ptr; reusable by other
// arbiters that keep their own pointer.
module rr_pick
   import fpga_modules_pkg::*;
#(
   parameter int in_val = 4,
   parameter int idx_w  = clog2_f(in_val)
) (
   input  logic [in_val-1:0] req,
   input  logic [idx_w-1:0]  ptr,
   output logic [in_val-1:0] pick_onehot,
   output logic [idx_w-1:0]  pick_idx,
   output logic              any
);

   logic [in_val-1:0]   hi_mask;
   logic [2*in_val-1:0] dbl;
   int                  pos;

   // Lower half holds only requests at/after ptr, upper half all requests,
   // so the lowest set bit of the double vector is the circular winner.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < in_val; i++) begin
         hi_mask[i] = (i >= int'(ptr));
      end
      dbl = {req, req & hi_mask};
      pos = 0;
      for (int i = 2*in_val-1; i >= 0; i--) begin
         if (dbl[i]) pos = i;
      end
      any         = |req;
      pick_idx    = idx_w'((pos >= in_val) ? (pos - in_val) : pos);
      pick_onehot = '0;
      if (any) pick_onehot[pick_idx] = 1'b1;
   end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot select that is held until
// the consumer releases it or the requester withdraws.
//
// state   | meaning
// --------+--------------------------------
// ST_IDLE | no grant active, arbitrate req
// ST_BUSY | grant latched, wait for release
module onehot_rr_arbiter
   import fpga_modules_pkg::*;
#(
   parameter int in_val = 4,
   parameter int idx_w  = clog2_f(in_val)
) (
   input  logic                clk,
   input  logic                rst,
   onehot_rr_arbiter_if.slave  bus
);

   arb_state_e        state_q, state_d;
   logic [idx_w-1:0]  ptr_q, ptr_d;
   logic [in_val-1:0] grant_q, grant_d;
   logic              grant_valid_q, grant_valid_d;
   logic [idx_w-1:0]  grant_idx_q, grant_idx_d;

   logic [in_val-1:0] pick_onehot;
   logic [idx_w-1:0]  pick_idx;
   logic              pick_any;

   rr_pick #(
      .in_val (in_val),
      .idx_w  (idx_w)
   ) u_pick (
      .req         (bus.req),
      .ptr         (ptr_q),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx),
      .any         (pick_any)
   );

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      grant_idx_d   = grant_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d       = pick_onehot;
               grant_idx_d   = pick_idx;
               grant_valid_d = 1'b1;
               // Explicit wrap so non-power-of-two requester counts rotate correctly.
               ptr_d         = (pick_idx == idx_w'(in_val-1)) ? '0 : pick_idx + idx_w'(1);
               state_d       = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus.release_pulse || !(|(bus.req & grant_q))) begin
               grant_d       = '0;
               grant_valid_d = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_idx_q   <= grant_idx_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Vector-table bench for onehot_rr_arbiter (4 requesters) with a 2-bit-slice
// AND-OR selector model on the grant output.
module tb_onehot_rr_arbiter;
   import fpga_modules_pkg::*;

   typedef struct {
      bit       rst_before;
      logic [3:0] req;
      bit       rel;
      logic [3:0] exp_grant;
      logic [1:0] exp_idx;
      bit       exp_valid;
      bit       chk_ptr;
      logic [1:0] exp_ptr;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t tbl[$];
   vec_t sb_q[$];
   logic [1:0] slice_data [4];

   onehot_rr_arbiter_if #(.in_val(4)) bus ();

   onehot_rr_arbiter #(.in_val(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] sel_out(input logic [3:0] g);
      logic [1:0] o;
      o = '0;
      for (int i = 0; i < 4; i++) o = o | (slice_data[i] & {2{g[i]}});
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input bit rb, input logic [3:0] r, input bit rl,
                               input logic [3:0] eg, input logic [1:0] ei, input bit ev,
                               input bit cp, input logic [1:0] ep);
      vec_t v;
      v.rst_before = rb; v.req = r; v.rel = rl;
      v.exp_grant = eg; v.exp_idx = ei; v.exp_valid = ev;
      v.chk_ptr = cp; v.exp_ptr = ep;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.req           = v.req;
      bus.release_pulse = v.rel;
      sb_q.push_back(v);
   endtask

   task automatic check_out();
      vec_t e;
      logic [1:0] exp_out;
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      exp_out = e.exp_valid ? slice_data[e.exp_idx] : 2'b00;
      chk("grant", 32'(bus.grant), 32'(e.exp_grant));
      chk("grant_valid", 32'(bus.grant_valid), 32'(e.exp_valid));
      chk("grant_idx", 32'(bus.grant_idx), 32'(e.exp_idx));
      chk("sel_out", 32'(sel_out(bus.grant)), 32'(exp_out));
      chk("onehot0", 32'($onehot0(bus.grant)), 32'd1);
      if (e.chk_ptr) chk("ptr", 32'(dut.ptr_q), 32'(e.exp_ptr));
   endtask

   task automatic step(input vec_t v);
      @(negedge clk);
      if (v.rst_before) begin
         rst = 1'b1;
         #1;
         rst = 1'b0;
      end
      drive(v);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      slice_data[0] = 2'b01;
      slice_data[1] = 2'b10;
      slice_data[2] = 2'b11;
      slice_data[3] = 2'b01;
      rst = 1'b1;
      bus.req = '0;
      bus.release_pulse = 1'b0;

      // single request, hold, release
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 1, 3));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 2, 0, 1, 3));
      // pointer skip and wrap
      tbl.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 1, 1));
      tbl.push_back(mk(0, 4'b0011, 1, 4'b0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0011, 0, 4'b0010, 1, 1, 1, 2));
      // BUSY ignores changes on other request lines
      tbl.push_back(mk(0, 4'b1110, 0, 4'b0010, 1, 1, 1, 2));
      // withdrawal, then release while idle
      tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 0, 1, 2));
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 1, 2));
      // rotation from a fresh reset
      tbl.push_back(mk(1, 4'b1111, 0, 4'b0001, 0, 1, 1, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 1, 1, 1, 2));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, 1, 1, 3));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 0, 4'b1000, 3, 1, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 3, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 1, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0));
      // simultaneous release and withdrawal
      tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 1, 1, 1, 2));
      tbl.push_back(mk(0, 4'b1101, 1, 4'b0000, 1, 0, 1, 2));
      tbl.push_back(mk(0, 4'b1101, 0, 4'b0100, 2, 1, 1, 3));
      tbl.push_back(mk(0, 4'b1101, 1, 4'b0000, 2, 0, 0, 0));
      // set up grant on requester 3 for the async reset case
      tbl.push_back(mk(0, 4'b1001, 0, 4'b1000, 3, 1, 1, 0));

      // reset state while rst is held
      #3;
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_valid", 32'(bus.grant_valid), 32'd0);
      chk("rst_idx", 32'(bus.grant_idx), 32'd0);
      chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // async reset between edges while grant is 1000
      #2;
      rst = 1'b1;
      #1;
      chk("async_grant", 32'(bus.grant), 32'd0);
      chk("async_valid", 32'(bus.grant_valid), 32'd0);
      chk("async_idx", 32'(bus.grant_idx), 32'd0);
      chk("async_ptr", 32'(dut.ptr_q), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(mk(0, 4'b1001, 0, 4'b0001, 0, 1, 1, 1));
      @(posedge clk);
      #1;
      check_out();

      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter that produces the registered one-hot select vector for the parametrised AND-OR selector stage downstream. It takes `in_val` request lines and holds one one-hot grant until the consumer releases it. Its `grant` output connects directly to the selector's `sel` input, so exactly one input slice or none reaches `out`.

## Interface
- `in_val`, default 4: number of requesters, which equals the width of the selector's `sel`. Legal range is 2..32.
- `idx_w`, default `$clog2(in_val)`: width of the binary grant index. Derived; not to be overridden.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset, asynchronous assert, active-high. All state clears immediately on assertion.
- `req`  input  `in_val`  request per requester. Level-sensitive. Each requester holds its bit until it is granted and released.
- `release`  input  1  single-cycle pulse from the consumer: the current transfer is finished. Ignored when no grant is active.
- `grant`  output  `in_val`  registered one-hot select for the selector. All-zero when idle. Reset value 0.
- `grant_valid`  output  1  OR of `grant`. Registered. Reset value 0.
- `grant_idx`  output  `idx_w`  binary index of the granted requester. Holds its last value while idle. Reset value 0.

## Operation
- The FSM has two states:
  - IDLE: no grant is active.
  - BUSY: a grant is latched.
  - Reset state is IDLE.
- Rotating priority pointer `ptr` (`idx_w` bits), reset value 0. Requester `ptr` has highest priority, then `ptr+1`, and so on, wrapping modulo `in_val`.
- IDLE with `req != 0`:
  - Pick the first set bit at or after `ptr`, searching circularly.
  - Register `grant` = that bit's one-hot, `grant_idx` = its index, `grant_valid` = 1.
  - Set `ptr` = (index+1) mod `in_val`. Wrap is explicit; `in_val` need not be a power of 2.
  - Go to BUSY.
- IDLE with `req == 0`: stay; outputs stay cleared.
- BUSY: hold `grant`, `grant_idx` and `ptr` unchanged, whatever `req` does.
- BUSY with `release` = 1, or with the granted `req` bit = 0 (requester withdrew):
  - Clear `grant` and `grant_valid`.
  - Go to IDLE.
- Requests are never re-arbitrated in the release cycle. There is always one idle bubble between grants.
- `release` and withdrawal in the same cycle count as one release.
- `release` in IDLE has no effect.
- `rst` mid-grant: outputs clear asynchronously, `ptr` returns to 0, state returns to IDLE. A pending `req` is arbitrated on the first clock edge after `rst` deasserts.
- `grant` is never multi-hot. A zero grant means the selector drives `out` = 0.

## Timing
- Request to grant: 1 cycle. `req` seen at edge N gives `grant` valid after edge N.
- Release to grant clear: 1 cycle. `release` at edge M clears `grant` after edge M.
- Release to next grant: `grant` is 0 for exactly one cycle, then the next grant follows at edge M+1 if any `req` is set.
- Maximum grant rate is one new grant every 2 cycles. Fairness bound: a held request waits at most `in_val`-1 grants.
- All outputs come straight from flops, with no combinational path from `req` or `release` to outputs. This keeps the selector's `sel` path glitch-free.

## Structure
- Shared package `fpga_modules_pkg`:
  - FSM state encoding (`ST_IDLE`, `ST_BUSY`).
  - A `clog2`-style width helper, for tools lacking `$clog2` in parameter context.
- One sub-module, `rr_pick`: purely combinational.
  - Inputs: `req`, `ptr`. Outputs: `pick_onehot`, `pick_idx`, `any`.
  - Implementation: double-width masked priority encode (requests at or above `ptr` first, then all).
  - It can be reused by later arbiters.
- Top level holds the FSM, the `ptr` register and the output registers.

## Test plan
All scenarios use `in_val` = 4.
- Reset, then single request: `rst` pulse, then `req`=4'b0100 → one cycle later `grant`=4'b0100, `grant_idx`=2, `grant_valid`=1, `ptr`=3. Hold `release`=0 for 5 cycles → `grant` is stable.
- Rotation: `req`=4'b1111 held, `release` pulsed every time a grant has been valid for 1 cycle → grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 (wrap).
- Pointer skip and wrap: `ptr`=3 after granting requester 2, then `req`=4'b0011 → `grant`=4'b0001, `ptr`=1. Next `req`=4'b0011 → `grant`=4'b0010.
- Withdrawal: while `grant`=4'b0010, drop `req[1]` → `grant`=0 the next cycle. `release` asserted in IDLE → no state change.
- Simultaneous release and withdrawal: both in the same cycle → a single return to IDLE; the next grant goes to the next requester in rotation.
- Async reset mid-grant: assert `rst` between clock edges while `grant`=4'b1000 → `grant`=0 and `grant_valid`=0 immediately, without waiting for a clock edge. After deassertion with `req`=4'b1001 → `grant`=4'b0001, since `ptr` was reset to 0.
- Connect to the selector (`in_size`=2) in every scenario → `out` always equals the granted slice, or 0 when idle.
